// File: rtl/montgomery_serial_core.sv
// montgomery_serial_core
//   Radix-2 bit-serial Montgomery multiplier. Computes
//   result = a * b * 2^-N mod m over N loop cycles, then does one
//   final conditional subtraction. Uses a start/done handshake.
//
//   Optional macro MONT_REG_OUT_EN adds an output register stage on
//   result/done. This adds one cycle of latency. busy stays high
//   through that extra cycle.
//
// Parameters
//   N   operand / modulus width (>= 4)
//   CW  iteration counter width (2^CW > N)
//
// Ports
//   clk     system clock, rising edge
//   resetn  asynchronous active-low reset
//   start   one-cycle request, sampled only while idle
//   in_a    multiplicand (< in_m)
//   in_b    multiplier   (< in_m)
//   in_m    modulus (odd, > 1)
//   result  fully reduced Montgomery product, held until next result
//   done    one-cycle pulse, result valid
//   busy    high from start acceptance until the end of the done cycle
module montgomery_serial_core #(
    parameter int N  = 1024,
    parameter int CW = 11
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done,
    output logic         busy
);

`ifdef MONT_REG_OUT_EN
    typedef enum logic [2:0] {S_IDLE, S_LOOP, S_SUB, S_OREG, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOOP, S_SUB, S_DONE} state_t;
`endif

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state;
    logic [N-1:0]   a_r;     // shifted right each iteration; bit 0 is a[i]
    logic [N-1:0]   b_r;
    logic [N-1:0]   m_r;
    logic [N+1:0]   t_r;     // accumulator; stays below 2m
    logic [CW-1:0]  cnt;
`ifdef MONT_REG_OUT_EN
    logic [N-1:0]   res_r;
`endif

    // One radix-2 step. The bound T + b + m < 4m needs all N+2 bits.
    logic [N+1:0] b_ext, m_ext, u_add, u_odd, t_next;
    logic [N+1:0] t_diff, sub_full;
    logic         t_ge_m;
    logic [N-1:0] sub_res;
    logic         unused_hi;

    assign b_ext  = {2'b00, b_r};
    assign m_ext  = {2'b00, m_r};
    assign u_add  = t_r + (a_r[0] ? b_ext : '0);
    // Adding odd m makes u even, so the shift below divides exactly by 2.
    assign u_odd  = u_add[0] ? (u_add + m_ext) : u_add;
    assign t_next = u_odd >> 1;

    assign t_ge_m    = (t_r >= m_ext);
    assign t_diff    = t_r - m_ext;
    assign sub_full  = t_ge_m ? t_diff : t_r;
    assign sub_res   = sub_full[N-1:0];
    // After the conditional subtract the top two bits are always zero.
    assign unused_hi = ^sub_full[N+1:N];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            m_r    <= '0;
            t_r    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
`ifdef MONT_REG_OUT_EN
            res_r  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r   <= in_a;
                        b_r   <= in_b;
                        m_r   <= in_m;
                        t_r   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_LOOP;
                    end
                end
                S_LOOP: begin
                    t_r <= t_next;
                    a_r <= a_r >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) state <= S_SUB;
                end
                S_SUB: begin
`ifdef MONT_REG_OUT_EN
                    res_r  <= sub_res;
                    state  <= S_OREG;
`else
                    result <= sub_res;
                    done   <= 1'b1;
                    state  <= S_DONE;
`endif
                end
`ifdef MONT_REG_OUT_EN
                S_OREG: begin
                    result <= res_r;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
`endif
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_serial_core.sv
module tb_montgomery_serial_core;

    localparam int N  = 8;
    localparam int CW = 4;
`ifdef MONT_REG_OUT_EN
    localparam int LAT = N + 3;
`else
    localparam int LAT = N + 2;
`endif

    logic         clk;
    logic         resetn;
    logic         start;
    logic [N-1:0] in_a, in_b, in_m;
    logic [N-1:0] result;
    logic         done, busy;

    int checks   = 0;
    int failures = 0;

    montgomery_serial_core #(.N(N), .CW(CW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in_a   (in_a),
        .in_b   (in_b),
        .in_m   (in_m),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the unique x < m with x * 2^N == a * b (mod m).
    function automatic int mont_ref(input int a, input int b, input int m);
        longint p;
        p = (longint'(a) * longint'(b)) % m;
        for (int x = 0; x < m; x++)
            if ((longint'(x) * (longint'(1) << N)) % m == p) return x;
        return -1;
    endfunction

    // Runs one operation from idle and observes LAT+2 cycles after acceptance.
    // Cycle 1 is the cycle right after the accepting edge.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] m, input int ign_at,
                          output logic [N-1:0] res, output int lat,
                          output int busy_cnt, output int dones,
                          output logic [N-1:0] res_end);
        res = '0; lat = 0; busy_cnt = 0; dones = 0;
        @(negedge clk);
        start = 1'b1; in_a = a; in_b = b; in_m = m;
        @(posedge clk); #1;
        start = 1'b0;
        in_a = N'($urandom); in_b = N'($urandom); in_m = N'($urandom);
        for (int c = 1; c <= LAT + 2; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                dones++;
                if (lat == 0) begin lat = c; res = result; end
            end
            start = (c == ign_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        res_end = result;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; in_a = '0; in_b = '0; in_m = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: result=%h done=%b busy=%b want 0/0/0", result, done, busy);
        end
        @(negedge clk); resetn = 1'b1;
    endtask

    task automatic test_vectors();
        logic [N-1:0] va [4] = '{8'h01, 8'h0F, 8'hF0, 8'h00};
        logic [N-1:0] vb [4] = '{8'h01, 8'h05, 8'hF0, 8'hAB};
        logic [N-1:0] ve [4] = '{8'hE1, 8'h05, 8'hE1, 8'h00};
        logic [N-1:0] res, res_end;
        int lat, bc, dn;
        for (int i = 0; i < 4; i++) begin
            // vector 3 also pulses start mid-operation; it must be ignored
            run_op(va[i], vb[i], 8'hF1, (i == 3) ? 4 : 0, res, lat, bc, dn, res_end);
            checks++;
            if (res !== ve[i]) begin
                failures++;
                $display("FAIL vec%0d_result: got %h want %h", i, res, ve[i]);
            end
            checks++;
            if (lat != LAT || dn != 1) begin
                failures++;
                $display("FAIL vec%0d_done: at cycle %0d count %0d want cycle %0d count 1", i, lat, dn, LAT);
            end
            checks++;
            if (bc != LAT) begin
                failures++;
                $display("FAIL vec%0d_busy: high %0d cycles want %0d", i, bc, LAT);
            end
            checks++;
            if (res_end !== ve[i]) begin
                failures++;
                $display("FAIL vec%0d_hold: got %h want %h", i, res_end, ve[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [N-1:0] res, res_end;
        int lat, bc, dn, late;
        // leave a nonzero result behind so the reset clearing is visible
        run_op(8'h01, 8'h01, 8'hF1, 0, res, lat, bc, dn, res_end);
        @(negedge clk);
        start = 1'b1; in_a = 8'h37; in_b = 8'h52; in_m = 8'hF1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #2; resetn = 1'b0; #1;
        checks++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_clear: result=%h done=%b busy=%b want 0/0/0", result, done, busy);
        end
        @(negedge clk); resetn = 1'b1;
        late = 0;
        for (int c = 0; c < LAT + 5; c++) begin
            @(posedge clk); #1;
            if (done || busy) late++;
        end
        checks++;
        if (late != 0) begin
            failures++;
            $display("FAIL abort_no_done: %0d active cycles after reset want 0", late);
        end
        run_op(8'h01, 8'h01, 8'hF1, 0, res, lat, bc, dn, res_end);
        checks++;
        if (res !== 8'hE1 || lat != LAT) begin
            failures++;
            $display("FAIL abort_rerun: result %h at cycle %0d want E1 at %0d", res, lat, LAT);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a, b, m, res, res_end;
        int lat, bc, dn, exp_r, bad;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            m = N'($urandom_range(1, 127) * 2 + 1);
            a = N'($urandom_range(0, int'(m) - 1));
            b = N'($urandom_range(0, int'(m) - 1));
            exp_r = mont_ref(int'(a), int'(b), int'(m));
            run_op(a, b, m, 0, res, lat, bc, dn, res_end);
            checks++;
            if (int'(res) != exp_r || lat != LAT || dn != 1) begin
                failures++; bad++;
                $display("FAIL rand%0d: a=%h b=%h m=%h got %h (cycle %0d) want %h (cycle %0d)",
                         i, a, b, m, res, lat, exp_r, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t_prev, n_done, exp_r, bad_gap, bad_res;
        exp_r = mont_ref(8'h5A, 8'h33, 8'hC7);
        t_prev = -1; n_done = 0; bad_gap = 0; bad_res = 0;
        @(negedge clk);
        start = 1'b1; in_a = 8'h5A; in_b = 8'h33; in_m = 8'hC7;
        for (int c = 0; c < 5 * (LAT + 1) + 2; c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (t_prev >= 0 && (c - t_prev) != LAT + 1) bad_gap++;
                if (int'(result) != exp_r) bad_res++;
                t_prev = c;
                n_done++;
            end
        end
        start = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        checks++;
        if (n_done < 4 || bad_gap != 0) begin
            failures++;
            $display("FAIL b2b_period: %0d dones, %0d bad gaps want >=4 dones every %0d cycles",
                     n_done, bad_gap, LAT + 1);
        end
        checks++;
        if (bad_res != 0) begin
            failures++;
            $display("FAIL b2b_result: %0d wrong results want %h each", bad_res, exp_r);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
